clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
- Front-panel sequencer for the clock's set mode.
- Converts three already-debounced push-button levels (mode/up/down) into the ctrl_set level, one-hot field select and single-cycle inc/dec strobes. These signals drive the second/minute/hour/day/month/year counters.
- Sits between the button debouncers and the counter chain.
- Returns the clock to run mode on request or after an inactivity timeout.

Parameters:
- TIMEOUT_S, 30, seconds of no button activity in a set state before forced return to RUN; legal range 2..255.
- HOLD_CYCLES, 50_000_000, clk cycles a button must stay held before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_CYCLES, 10_000_000, clk cycles between auto-repeat strobes (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick_1hz  input  1  one-cycle pulse per second, from the seconds prescaler
- btn_mode  input  1  debounced level, 1 = pressed
- btn_up  input  1  debounced level, 1 = pressed
- btn_down  input  1  debounced level, 1 = pressed
- ctrl_set  output  1  1 in any SET state; gates counters out of normal carry chaining
- field_sel  output  6  one-hot {year,month,day,hour,min,sec}; 0 in RUN
- inc  output  1  one-cycle increment strobe for the selected field
- dec  output  1  one-cycle decrement strobe for the selected field
- blink  output  1  display blink enable for the selected field

Behaviour:
- Reset:
  - Asynchronous and active-low.
  - Forces state RUN and clears all button-history registers and counters.
  - All outputs reset to 0: ctrl_set, field_sel, inc, dec, blink.
- Edge detect:
  - Each button is registered once (prev).
  - A rising edge at cycle N means level=1 and prev=0.
  - Only rising edges act; holding a button does nothing except under AUTO_REPEAT_EN.
- State machine:
  - States: RUN, SET_SEC, SET_MIN, SET_HOUR, SET_DAY, SET_MONTH, SET_YEAR.
  - A mode edge advances RUN->SET_SEC->SET_MIN->SET_HOUR->SET_DAY->SET_MONTH->SET_YEAR->RUN.
  - The state register updates at the end of edge cycle N.
  - ctrl_set and field_sel are registered and valid from cycle N+1.
  - field_sel bit0 is sec, bit5 is year.
- Strobes:
  - In a SET state, an up edge at cycle N gives inc=1 for exactly cycle N+1; a down edge gives dec=1 for exactly cycle N+1.
  - inc and dec are never both 1.
  - Both are 0 in RUN; up/down edges in RUN are ignored.
- Simultaneous events:
  - Mode edge together with an up or down edge: the mode edge wins and no strobe is issued.
  - Up and down edges in the same cycle: both are ignored.
- Timeout:
  - An 8-bit idle counter clears on any button rising edge and on every state change.
  - In a SET state it increments on tick_1hz.
  - If the counter equals TIMEOUT_S-1 when tick_1hz arrives, the state becomes RUN next cycle.
  - The counter is held at 0 in RUN.
- Blink:
  - In a SET state, blink toggles on each tick_1hz.
  - blink is forced to 1 for the cycle after every inc/dec strobe so an edited field stays visible.
  - blink is 0 in RUN.
  - On entering a SET state from RUN, blink starts at 1.
- Reset mid-set: the FSM returns to RUN immediately (asynchronous) and no strobe is emitted.

Optional Feature:
- Macro: CLOCK_SET_AUTO_REPEAT_EN.
- With the macro defined:
  - A per-direction hold counter starts at the up or down edge.
  - When it reaches HOLD_CYCLES with the button still held, an extra strobe is issued, then another every REPEAT_CYCLES.
  - Releasing the button, pressing the other direction, a mode edge or leaving the SET state clears the counter.
  - Repeat strobes also clear the idle timeout counter.
- Without the macro: one strobe per press only, the hold counters are not built, and HOLD_CYCLES/REPEAT_CYCLES are unused.

Test Plan:
- Reset then 6 mode presses -> field_sel sequence 000001,000010,000100,001000,010000,100000; 7th press -> RUN, ctrl_set=0, field_sel=0.
- In SET_MIN, 3 up presses then 1 down press -> exactly 3 single-cycle inc pulses then 1 dec pulse, each one cycle after its edge, field_sel=000010 throughout.
- btn_mode and btn_up rise in the same cycle in SET_SEC -> state SET_MIN, no inc pulse; btn_up and btn_down rising together -> no strobe.
- TIMEOUT_S=3, enter SET_HOUR, apply 3 tick_1hz pulses with no buttons -> RUN after the 3rd; repeating with an up press after the 2nd tick -> still in SET_HOUR after the 3rd tick.
- rst_n pulled low while in SET_DAY with btn_up held -> all outputs 0 asynchronously; after release, state RUN and no inc issued.
- With CLOCK_SET_AUTO_REPEAT_EN, HOLD_CYCLES=10, REPEAT_CYCLES=4, hold btn_up 25 cycles in SET_SEC -> inc at edge+1, then at +10, +14, +18, +22 (5 total); without the macro -> 1 inc total.

Source files
------------

// File: rtl/clock_set_controller.sv
// Set-mode sequencer: turns debounced mode/up/down levels into ctrl_set, one-hot field_sel, inc/dec strobes and blink.
// Optional hold-to-repeat strobes are built only when CLOCK_SET_AUTO_REPEAT_EN is defined.
module clock_set_controller #(
   parameter int TIMEOUT_S     = 30,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       ctrl_set,
   output logic [5:0] field_sel,
   output logic       inc,
   output logic       dec,
   output logic       blink
);

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      SET_SEC   = 3'd1,
      SET_MIN   = 3'd2,
      SET_HOUR  = 3'd3,
      SET_DAY   = 3'd4,
      SET_MONTH = 3'd5,
      SET_YEAR  = 3'd6
   } state_t;

   // An out-of-range parameter set disables the timeout instead of misfiring.
   localparam logic       P_LEGAL   = (TIMEOUT_S >= 2) && (TIMEOUT_S <= 255) &&
                                      (HOLD_CYCLES >= 1) && (REPEAT_CYCLES >= 1);
   localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_S - 1);

   state_t     r_state, w_state_nxt;
   logic       r_prev_mode, r_prev_up, r_prev_down;
   logic       r_ctrl_set, r_inc, r_dec, r_blink;
   logic [5:0] r_field_sel, w_field_nxt;
   logic [7:0] r_idle;
   logic       w_mode_edge, w_up_edge, w_dn_edge, w_in_set;
   logic       w_up_acc, w_dn_acc, w_rep_up, w_rep_dn, w_activity, w_timeout;

   assign w_mode_edge = btn_mode & ~r_prev_mode;
   assign w_up_edge   = btn_up   & ~r_prev_up;
   assign w_dn_edge   = btn_down & ~r_prev_down;
   assign w_in_set    = (r_state != RUN);
   assign w_up_acc    = w_in_set & w_up_edge & ~w_dn_edge & ~w_mode_edge;
   assign w_dn_acc    = w_in_set & w_dn_edge & ~w_up_edge & ~w_mode_edge;
   assign w_activity  = w_mode_edge | w_up_edge | w_dn_edge | w_rep_up | w_rep_dn;
   // Any button activity in the same cycle as the deadline counts as the user still being present.
   assign w_timeout   = P_LEGAL & w_in_set & tick_1hz & (r_idle == IDLE_LAST) & ~w_activity;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
   logic [1:0][31:0] r_hold_cnt;
   logic [1:0]       r_hold_act, r_hold_rep;
   logic [1:0]       w_start, w_stop, w_rep_fire;

   assign w_start   = {w_dn_acc, w_up_acc};
   assign w_stop[0] = ~btn_up   | w_dn_edge | w_mode_edge | ~w_in_set;
   assign w_stop[1] = ~btn_down | w_up_edge | w_mode_edge | ~w_in_set;

   always_comb begin
      w_rep_fire = 2'b00;
      for (int d = 0; d < 2; d++) begin
         w_rep_fire[d] = r_hold_act[d] & ~w_stop[d] &
                         (r_hold_rep[d] ? (r_hold_cnt[d] == 32'(REPEAT_CYCLES - 1))
                                        : (r_hold_cnt[d] == 32'(HOLD_CYCLES - 1)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_cnt <= '0;
         r_hold_act <= 2'b00;
         r_hold_rep <= 2'b00;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (w_start[d]) begin
               r_hold_cnt[d] <= 32'd1;
               r_hold_act[d] <= 1'b1;
               r_hold_rep[d] <= 1'b0;
            end else if (w_stop[d] || w_timeout) begin
               r_hold_cnt[d] <= '0;
               r_hold_act[d] <= 1'b0;
               r_hold_rep[d] <= 1'b0;
            end else if (w_rep_fire[d]) begin
               r_hold_cnt[d] <= '0;
               r_hold_rep[d] <= 1'b1;
            end else if (r_hold_act[d]) begin
               r_hold_cnt[d] <= r_hold_cnt[d] + 32'd1;
            end
         end
      end
   end

   assign w_rep_up = w_rep_fire[0];
   assign w_rep_dn = w_rep_fire[1];
`else
   assign w_rep_up = 1'b0;
   assign w_rep_dn = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      if (w_mode_edge) begin
         case (r_state)
            RUN:       w_state_nxt = SET_SEC;
            SET_SEC:   w_state_nxt = SET_MIN;
            SET_MIN:   w_state_nxt = SET_HOUR;
            SET_HOUR:  w_state_nxt = SET_DAY;
            SET_DAY:   w_state_nxt = SET_MONTH;
            SET_MONTH: w_state_nxt = SET_YEAR;
            default:   w_state_nxt = RUN;
         endcase
      end else if (w_timeout) begin
         w_state_nxt = RUN;
      end
   end

   always_comb begin
      w_field_nxt = 6'b000000;
      case (w_state_nxt)
         SET_SEC:   w_field_nxt = 6'b000001;
         SET_MIN:   w_field_nxt = 6'b000010;
         SET_HOUR:  w_field_nxt = 6'b000100;
         SET_DAY:   w_field_nxt = 6'b001000;
         SET_MONTH: w_field_nxt = 6'b010000;
         SET_YEAR:  w_field_nxt = 6'b100000;
         default:   w_field_nxt = 6'b000000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RUN;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_mode <= 1'b0;
         r_prev_up   <= 1'b0;
         r_prev_down <= 1'b0;
         r_ctrl_set  <= 1'b0;
         r_field_sel <= 6'b000000;
         r_inc       <= 1'b0;
         r_dec       <= 1'b0;
         r_blink     <= 1'b0;
         r_idle      <= 8'd0;
      end else begin
         r_prev_mode <= btn_mode;
         r_prev_up   <= btn_up;
         r_prev_down <= btn_down;
         r_ctrl_set  <= (w_state_nxt != RUN);
         r_field_sel <= w_field_nxt;
         r_inc       <= w_up_acc | w_rep_up;
         r_dec       <= w_dn_acc | w_rep_dn;

         if (w_state_nxt == RUN)      r_blink <= 1'b0;
         else if (!w_in_set)          r_blink <= 1'b1;
         else if (r_inc || r_dec)     r_blink <= 1'b1;
         else if (tick_1hz)           r_blink <= ~r_blink;

         if (!w_in_set || (w_state_nxt != r_state) || w_activity) r_idle <= 8'd0;
         else if (tick_1hz)                                        r_idle <= r_idle + 8'd1;
      end
   end

   assign ctrl_set  = r_ctrl_set;
   assign field_sel = r_field_sel;
   assign inc       = r_inc;
   assign dec       = r_dec;
   assign blink     = r_blink;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: mode cycling, strobes, simultaneous edges, timeout, reset and auto-repeat.
module tb_clock_set_controller;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       ctrl_set;
   logic [5:0] field_sel;
   logic       inc, dec, blink;

   int checks = 0;
   int errors = 0;

   clock_set_controller #(
      .TIMEOUT_S(3),
      .HOLD_CYCLES(10),
      .REPEAT_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tick_1hz(tick_1hz),
      .btn_mode(btn_mode),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .ctrl_set(ctrl_set),
      .field_sel(field_sel),
      .inc(inc),
      .dec(dec),
      .blink(blink)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; tick_1hz = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic press_mode(input int n);
      for (int i = 0; i < n; i++) begin
         btn_mode = 1'b1; cyc();
         btn_mode = 1'b0; cyc();
      end
   endtask

   task automatic pulse_tick();
      tick_1hz = 1'b1; cyc();
      tick_1hz = 1'b0; cyc();
   endtask

   task automatic test_reset();
      cyc(); cyc();
      checks++;
      if ({ctrl_set, field_sel, inc, dec, blink} !== 10'd0) begin
         errors++; $display("FAIL reset_outputs: got %b expected 0000000000", {ctrl_set, field_sel, inc, dec, blink});
      end
      rst_n = 1'b1;
      cyc(); cyc();
      checks++;
      if ({ctrl_set, field_sel, inc, dec, blink} !== 10'd0) begin
         errors++; $display("FAIL post_reset_idle: got %b expected 0000000000", {ctrl_set, field_sel, inc, dec, blink});
      end
   endtask

   task automatic test_mode_cycle();
      logic [5:0] exp_f;
      btn_up = 1'b1; cyc();
      checks++;
      if (inc !== 1'b0 || ctrl_set !== 1'b0) begin
         errors++; $display("FAIL run_up_ignored: inc=%b ctrl_set=%b expected 0 0", inc, ctrl_set);
      end
      btn_up = 1'b0; cyc();
      for (int i = 0; i < 6; i++) begin
         exp_f = 6'd1 << i;
         btn_mode = 1'b1; cyc();
         checks++;
         if (field_sel !== exp_f || ctrl_set !== 1'b1) begin
            errors++; $display("FAIL mode_step%0d: field_sel=%b ctrl_set=%b expected %b 1", i, field_sel, ctrl_set, exp_f);
         end
         if (i == 0) begin
            checks++;
            if (blink !== 1'b1) begin
               errors++; $display("FAIL blink_on_entry: got %b expected 1", blink);
            end
         end
         btn_mode = 1'b0; cyc();
      end
      btn_mode = 1'b1; cyc();
      checks++;
      if ({ctrl_set, field_sel, blink} !== 8'd0) begin
         errors++; $display("FAIL mode_wrap_run: got %b expected 00000000", {ctrl_set, field_sel, blink});
      end
      btn_mode = 1'b0; cyc();
   endtask

   task automatic test_strobes();
      do_reset();
      press_mode(2);
      pulse_tick();
      checks++;
      if (blink !== 1'b0) begin
         errors++; $display("FAIL blink_toggle: got %b expected 0", blink);
      end
      for (int i = 0; i < 3; i++) begin
         btn_up = 1'b1; cyc();
         checks++;
         if (inc !== 1'b1 || dec !== 1'b0 || field_sel !== 6'b000010) begin
            errors++; $display("FAIL up_strobe%0d: inc=%b dec=%b field_sel=%b expected 1 0 000010", i, inc, dec, field_sel);
         end
         btn_up = 1'b0; cyc();
         checks++;
         if (inc !== 1'b0 || blink !== 1'b1) begin
            errors++; $display("FAIL up_after%0d: inc=%b blink=%b expected 0 1", i, inc, blink);
         end
      end
      btn_down = 1'b1; cyc();
      checks++;
      if (dec !== 1'b1 || inc !== 1'b0 || field_sel !== 6'b000010) begin
         errors++; $display("FAIL down_strobe: dec=%b inc=%b field_sel=%b expected 1 0 000010", dec, inc, field_sel);
      end
      btn_down = 1'b0; cyc();
      checks++;
      if (dec !== 1'b0) begin
         errors++; $display("FAIL down_single: dec=%b expected 0", dec);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      press_mode(1);
      btn_mode = 1'b1; btn_up = 1'b1; cyc();
      checks++;
      if (field_sel !== 6'b000010 || inc !== 1'b0) begin
         errors++; $display("FAIL mode_beats_up: field_sel=%b inc=%b expected 000010 0", field_sel, inc);
      end
      btn_mode = 1'b0; btn_up = 1'b0; cyc();
      btn_up = 1'b1; btn_down = 1'b1; cyc();
      checks++;
      if (inc !== 1'b0 || dec !== 1'b0) begin
         errors++; $display("FAIL up_down_cancel: inc=%b dec=%b expected 0 0", inc, dec);
      end
      btn_up = 1'b0; btn_down = 1'b0; cyc();
      checks++;
      if (inc !== 1'b0 || dec !== 1'b0 || field_sel !== 6'b000010) begin
         errors++; $display("FAIL up_down_after: inc=%b dec=%b field_sel=%b expected 0 0 000010", inc, dec, field_sel);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      press_mode(3);
      pulse_tick();
      pulse_tick();
      checks++;
      if (field_sel !== 6'b000100) begin
         errors++; $display("FAIL timeout_early: field_sel=%b expected 000100", field_sel);
      end
      tick_1hz = 1'b1; cyc();
      checks++;
      if ({ctrl_set, field_sel, blink} !== 8'd0) begin
         errors++; $display("FAIL timeout_run: got %b expected 00000000", {ctrl_set, field_sel, blink});
      end
      tick_1hz = 1'b0; cyc();

      do_reset();
      press_mode(3);
      pulse_tick();
      pulse_tick();
      btn_up = 1'b1; cyc();
      btn_up = 1'b0; cyc();
      pulse_tick();
      checks++;
      if (field_sel !== 6'b000100 || ctrl_set !== 1'b1) begin
         errors++; $display("FAIL timeout_rearm: field_sel=%b ctrl_set=%b expected 000100 1", field_sel, ctrl_set);
      end
      pulse_tick();
      tick_1hz = 1'b1; cyc();
      checks++;
      if (ctrl_set !== 1'b0 || field_sel !== 6'b000000) begin
         errors++; $display("FAIL timeout_rearm_expire: ctrl_set=%b field_sel=%b expected 0 000000", ctrl_set, field_sel);
      end
      tick_1hz = 1'b0; cyc();
   endtask

   task automatic test_reset_mid_set();
      int n_inc;
      do_reset();
      press_mode(4);
      btn_up = 1'b1; cyc();
      checks++;
      if (inc !== 1'b1 || field_sel !== 6'b001000) begin
         errors++; $display("FAIL day_inc: inc=%b field_sel=%b expected 1 001000", inc, field_sel);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ctrl_set, field_sel, inc, dec, blink} !== 10'd0) begin
         errors++; $display("FAIL async_reset: got %b expected 0000000000", {ctrl_set, field_sel, inc, dec, blink});
      end
      cyc(); cyc();
      rst_n = 1'b1;
      n_inc = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (inc === 1'b1) n_inc++;
      end
      checks++;
      if (n_inc !== 0 || ctrl_set !== 1'b0) begin
         errors++; $display("FAIL reset_held_up: incs=%0d ctrl_set=%b expected 0 0", n_inc, ctrl_set);
      end
      btn_up = 1'b0; cyc();
   endtask

   task automatic test_auto_repeat();
      logic [24:0] obs;
      logic [24:0] exp_obs;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      exp_obs = 25'h0222201;
`else
      exp_obs = 25'h0000001;
`endif
      do_reset();
      press_mode(1);
      obs = '0;
      btn_up = 1'b1;
      for (int k = 0; k < 25; k++) begin
         cyc();
         obs[k] = inc;
      end
      btn_up = 1'b0; cyc();
      checks++;
      if (obs !== exp_obs) begin
         errors++; $display("FAIL hold_pattern: got %h expected %h", obs, exp_obs);
      end
      checks++;
      if (inc !== 1'b0 || field_sel !== 6'b000001) begin
         errors++; $display("FAIL hold_release: inc=%b field_sel=%b expected 0 000001", inc, field_sel);
      end
   endtask

   initial begin
      test_reset();
      test_mode_cycle();
      test_strobes();
      test_simultaneous();
      test_timeout();
      test_reset_mid_set();
      test_auto_repeat();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
